// File: rtl/cram_store_pkg.sv
// Shared EBOX definitions for the CRAM store: microword types, group geometry
// and the diagnostic load FSM state encoding.
package cram_store_pkg;

    localparam int unsigned CRADR_W    = 11;
    localparam int unsigned CRAM_W     = 84;
    localparam int unsigned CRAM_GRP_W = 21;
    localparam int unsigned CRAM_DEPTH = 2048;

    typedef logic [CRADR_W-1:0] tCRADR;
    typedef logic [CRAM_W-1:0]  tCRAMword;

    // Encoding is visible on the diagnostic status readback
    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StStage  = 2'b01,
        StCommit = 2'b10
    } cram_state_e;

    // Bit 0 is the MSB, so group 0 occupies the top 21 bits of the word
    function automatic logic [CRAM_GRP_W-1:0] cram_get_group(tCRAMword w, logic [1:0] g);
        case (g)
            2'd0:    return w[83:63];
            2'd1:    return w[62:42];
            2'd2:    return w[41:21];
            default: return w[20:0];
        endcase
    endfunction

    function automatic tCRAMword cram_set_group(tCRAMword w, logic [1:0] g,
                                                logic [CRAM_GRP_W-1:0] v);
        tCRAMword r;
        r = w;
        case (g)
            2'd0:    r[83:63] = v;
            2'd1:    r[62:42] = v;
            2'd2:    r[41:21] = v;
            default: r[20:0]  = v;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/cram_store_ram.sv
// CRAM storage array: synchronous read, single write port, no reset on contents.
module cram_ram
    import cram_store_pkg::*;
#(
    parameter int unsigned Width = CRAM_W
) (
    input  logic             clk,
    input  logic             RESET,
    input  tCRADR            raddr,
    output logic [Width-1:0] rdata,
    input  logic             we,
    input  tCRADR            waddr,
    input  logic [Width-1:0] wdata
);

    logic [Width-1:0] mem_q [CRAM_DEPTH];

    // Write port; contents deliberately survive RESET
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    // Registered read; a same-address write in the same cycle returns old data
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            rdata <= '0;
        end else begin
            rdata <= mem_q[raddr];
        end
    end

endmodule

// File: rtl/cram_store.sv
// CRAM store: microword storage with registered read and a diagnostic
// group-staged write path. Optional odd parity enabled by CRAM_PARITY_EN.
module cram_store
    import cram_store_pkg::*;
(
    input  logic        clk,
    input  logic        RESET,
    input  logic [10:0] cradr,
    input  logic        diag_load,
    input  logic        diag_read,
    input  logic [2:0]  diag_sel,
    input  logic [35:0] ebus_in,
    output logic [83:0] cram_word,
    output logic [35:0] ebus_out,
    output logic        ebus_driving,
    output logic        par_err
);

`ifdef CRAM_PARITY_EN
    localparam int unsigned RamW = CRAM_W + 1;
`else
    localparam int unsigned RamW = CRAM_W;
`endif

    cram_state_e     state_q;
    logic [3:0]      mask_q;
    tCRAMword        staging_q;
    tCRADR           diag_adr_q;
    logic [RamW-1:0] ram_rdata;
    logic [RamW-1:0] ram_wdata;
    logic            ram_we;
    logic [3:0]      grp_bit;
    logic            unused_ebus;

    assign unused_ebus = ^ebus_in[14:0];
    assign grp_bit     = 4'b0001 << diag_sel[1:0];
    // Gate with RESET so a reset coincident with the commit edge blocks the write
    assign ram_we      = (state_q == StCommit) && !RESET;

`ifdef CRAM_PARITY_EN
    assign ram_wdata = {~^staging_q, staging_q};
`else
    assign ram_wdata = staging_q;
`endif

    assign cram_word = ram_rdata[CRAM_W-1:0];

    cram_ram #(
        .Width (RamW)
    ) u_ram (
        .clk   (clk),
        .RESET (RESET),
        .raddr (cradr),
        .rdata (ram_rdata),
        .we    (ram_we),
        .waddr (diag_adr_q),
        .wdata (ram_wdata)
    );

    // Diagnostic load FSM: stage four groups, then commit for exactly one cycle
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            staging_q  <= '0;
            diag_adr_q <= '0;
        end else begin
            case (state_q)
                StCommit: begin
                    state_q <= StIdle;
                    mask_q  <= '0;
                end
                default: begin
                    if (diag_load) begin
                        if (diag_sel[2]) begin
                            staging_q <= cram_set_group(staging_q, diag_sel[1:0],
                                                        ebus_in[35 -: CRAM_GRP_W]);
                            mask_q    <= mask_q | grp_bit;
                            state_q   <= ((mask_q | grp_bit) == 4'hF) ? StCommit : StStage;
                        end else if (diag_sel == 3'b001) begin
                            diag_adr_q <= ebus_in[35 -: CRADR_W];
                        end else if (diag_sel == 3'b000) begin
                            mask_q  <= '0;
                            state_q <= StIdle;
                        end
                    end
                end
            endcase
        end
    end

`ifdef CRAM_PARITY_EN
    logic rd_valid_q;
    logic par_err_q;
    logic diag_clr;

    assign diag_clr = diag_load && (diag_sel == 3'b000) && (state_q != StCommit);

    // Sticky parity error; rd_valid_q masks the reset value of the read register
    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            rd_valid_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b1;
            if (diag_clr) begin
                par_err_q <= 1'b0;
            end else if (rd_valid_q && !(^ram_rdata)) begin
                par_err_q <= 1'b1;
            end
        end
    end

    assign par_err = par_err_q;
`else
    assign par_err = 1'b0;
`endif

    assign ebus_driving = diag_read;

    // Diagnostic readback mux, bit 0 of the EBUS is the MSB
    always_comb begin
        ebus_out = '0;
        if (diag_read) begin
            if (diag_sel[2]) begin
                ebus_out[35 -: CRAM_GRP_W] = cram_get_group(cram_word, diag_sel[1:0]);
            end else if (diag_sel == 3'b000) begin
                ebus_out[35 -: 7] = {mask_q[0], mask_q[1], mask_q[2], mask_q[3],
                                     state_q, par_err};
            end else if (diag_sel == 3'b001) begin
                ebus_out[35 -: CRADR_W] = diag_adr_q;
            end
        end
    end

endmodule

// File: tb/tb_cram_store.sv
// Directed self-checking bench for cram_store.
module tb_cram_store;

    logic        clk = 1'b0;
    logic        RESET;
    logic [10:0] cradr;
    logic        diag_load;
    logic        diag_read;
    logic [2:0]  diag_sel;
    logic [35:0] ebus_in;
    logic [83:0] cram_word;
    logic [35:0] ebus_out;
    logic        ebus_driving;
    logic        par_err;

    int n_chk  = 0;
    int n_fail = 0;

    localparam logic [83:0] P1 = {21'h1FFFFF, 21'h000000, 21'h0AAAAA, 21'h155555};
    localparam logic [83:0] P2 = {21'h012345, 21'h1ABCDE, 21'h00F0F0, 21'h1FFFF0};
    localparam logic [83:0] P3 = {21'h111111, 21'h022222, 21'h033333, 21'h044444};

`ifdef CRAM_PARITY_EN
    // Parity status is checked in its own section; reads of unwritten words may set it
    localparam logic [35:0] STAT_MASK = ~(36'h1 << 29);
`else
    localparam logic [35:0] STAT_MASK = {36{1'b1}};
`endif

    typedef struct {
        logic        rd;
        logic [2:0]  sel;
        logic [35:0] exp;
    } rd_vec_t;

    rd_vec_t tbl [10];

    cram_store u_dut (
        .clk          (clk),
        .RESET        (RESET),
        .cradr        (cradr),
        .diag_load    (diag_load),
        .diag_read    (diag_read),
        .diag_sel     (diag_sel),
        .ebus_in      (ebus_in),
        .cram_word    (cram_word),
        .ebus_out     (ebus_out),
        .ebus_driving (ebus_driving),
        .par_err      (par_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "bench timeout");
    end

    function automatic logic [35:0] stat(logic [3:0] m, logic [1:0] st, logic pe);
        return {m, st, pe, 29'b0};
    endfunction

    task automatic chk(input string name, input logic [83:0] act, input logic [83:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Combinational status readback, called just after a negedge
    task automatic rd_stat(input string name, input logic [35:0] exp);
        diag_read = 1'b1;
        diag_sel  = 3'b000;
        #1;
        chk(name, {48'b0, ebus_out & STAT_MASK}, {48'b0, exp & STAT_MASK});
        diag_read = 1'b0;
    endtask

    task automatic rd_adr(input string name, input logic [10:0] exp);
        diag_read = 1'b1;
        diag_sel  = 3'b001;
        #1;
        chk(name, {48'b0, ebus_out}, {48'b0, exp, 25'b0});
        diag_read = 1'b0;
        diag_sel  = 3'b000;
    endtask

    task automatic diag_cmd(input logic [2:0] sel, input logic [35:0] data);
        diag_load = 1'b1;
        diag_sel  = sel;
        ebus_in   = data;
        @(negedge clk);
        diag_load = 1'b0;
        diag_sel  = 3'b000;
        ebus_in   = '0;
    endtask

    // Ends at the negedge inside the COMMIT cycle
    task automatic load_word(input logic [10:0] adr, input logic [83:0] w);
        diag_cmd(3'b001, {adr, 25'b0});
        for (int g = 0; g < 4; g++) begin
            diag_cmd(3'(4 + g), {w[83 - 21*g -: 21], 15'b0});
        end
    endtask

    initial begin
        tbl[0] = '{1'b1, 3'b100, {21'h1FFFFF, 15'b0}};
        tbl[1] = '{1'b1, 3'b101, 36'h0};
        tbl[2] = '{1'b1, 3'b110, {21'h0AAAAA, 15'b0}};
        tbl[3] = '{1'b1, 3'b111, {21'h155555, 15'b0}};
        tbl[4] = '{1'b1, 3'b001, {11'h123, 25'b0}};
        tbl[5] = '{1'b1, 3'b010, 36'h0};
        tbl[6] = '{1'b1, 3'b011, 36'h0};
        tbl[7] = '{1'b0, 3'b100, 36'h0};
        tbl[8] = '{1'b0, 3'b001, 36'h0};
        tbl[9] = '{1'b1, 3'b000, 36'h0};

        RESET     = 1'b1;
        cradr     = '0;
        diag_load = 1'b0;
        diag_read = 1'b0;
        diag_sel  = '0;
        ebus_in   = '0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk("reset_cram_word", cram_word, '0);
        rd_stat("reset_status", stat(4'b0000, 2'b00, 1'b0));
        rd_adr("reset_diag_adr", 11'h000);
        RESET = 1'b0;
        @(negedge clk);

        // Full four-group commit to 0x123
        load_word(11'h123, P1);
        rd_stat("commit_status", stat(4'b1111, 2'b10, 1'b0));
        @(negedge clk);
        rd_stat("after_commit_idle", stat(4'b0000, 2'b00, 1'b0));
        cradr = 11'h123;
        @(negedge clk);
        chk("read_0x123", cram_word, P1);

        // Readback table against the committed word at 0x123
        for (int i = 0; i < 10; i++) begin
            diag_read = tbl[i].rd;
            diag_sel  = tbl[i].sel;
            #1;
            chk($sformatf("rdtbl%0d_ebus", i), {48'b0, ebus_out & STAT_MASK},
                {48'b0, tbl[i].exp & STAT_MASK});
            chk($sformatf("rdtbl%0d_drv", i), {83'b0, ebus_driving}, {83'b0, tbl[i].rd});
        end
        diag_read = 1'b0;
        diag_sel  = 3'b000;
        @(negedge clk);

        // Partial staging, status mid-STAGE, overwrite, and abort by sel=000
        diag_cmd(3'b100, {21'h0ABCDE, 15'b0});
        diag_cmd(3'b110, {21'h012345, 15'b0});
        rd_stat("stage_0_2_status", stat(4'b1010, 2'b01, 1'b0));
        #1;
        chk("idle_ebus_zero", {48'b0, ebus_out}, '0);
        chk("idle_not_driving", {83'b0, ebus_driving}, '0);
        diag_cmd(3'b100, {21'h1FFFFF, 15'b0});
        rd_stat("reload_same_state", stat(4'b1010, 2'b01, 1'b0));
        diag_cmd(3'b000, '0);
        rd_stat("abort_to_idle", stat(4'b0000, 2'b00, 1'b0));

        // Same-address commit: old word during COMMIT edge, new word after
        load_word(11'h7FF, P1);
        cradr = 11'h7FF;
        @(negedge clk);
        load_word(11'h7FF, P2);
        chk("rbw_before", cram_word, P1);
        // This load lands in COMMIT and must be ignored
        diag_cmd(3'b001, {11'h055, 25'b0});
        chk("rbw_old_word", cram_word, P1);
        rd_stat("rbw_idle", stat(4'b0000, 2'b00, 1'b0));
        rd_adr("commit_ignores_load", 11'h7FF);
        @(negedge clk);
        chk("rbw_new_word", cram_word, P2);

        // Reset during STAGE aborts the sequence
        diag_cmd(3'b100, {21'h000001, 15'b0});
        diag_cmd(3'b101, {21'h000002, 15'b0});
        diag_cmd(3'b101, {21'h000003, 15'b0});
        diag_cmd(3'b110, {21'h000004, 15'b0});
        rd_stat("stage_3grp_status", stat(4'b1110, 2'b01, 1'b0));
        RESET = 1'b1;
        @(negedge clk);
        chk("reset_mid_cram_word", cram_word, '0);
        rd_stat("reset_mid_status", stat(4'b0000, 2'b00, 1'b0));
        RESET = 1'b0;
        diag_cmd(3'b111, {21'h000005, 15'b0});
        rd_stat("after_reset_one_grp", stat(4'b0001, 2'b01, 1'b0));
        diag_cmd(3'b000, '0);
        chk("storage_kept_stage", cram_word, P2);

        // Reset during COMMIT blocks the write
        load_word(11'h7FF, P3);
        #1;
        RESET = 1'b1;
        @(negedge clk);
        RESET = 1'b0;
        rd_adr("diag_adr_reset", 11'h000);
        @(negedge clk);
        @(negedge clk);
        chk("storage_kept_commit", cram_word, P2);

`ifdef CRAM_PARITY_EN
        // Parity: flip the stored parity bit of 0x010 and watch par_err stick
        load_word(11'h010, P1);
        @(negedge clk);
        cradr = 11'h010;
        @(negedge clk);
        diag_cmd(3'b000, '0);
        @(negedge clk);
        chk("par_clean", {83'b0, par_err}, '0);
        u_dut.u_ram.mem_q[16][84] = ~u_dut.u_ram.mem_q[16][84];
        @(negedge clk);
        @(negedge clk);
        chk("par_set", {83'b0, par_err}, 84'd1);
        cradr = 11'h123;
        @(negedge clk);
        @(negedge clk);
        chk("par_sticky", {83'b0, par_err}, 84'd1);
        diag_read = 1'b1;
        diag_sel  = 3'b000;
        #1;
        chk("par_status_bit", {83'b0, ebus_out[29]}, 84'd1);
        diag_read = 1'b0;
        @(negedge clk);
        diag_cmd(3'b000, '0);
        @(negedge clk);
        chk("par_cleared", {83'b0, par_err}, '0);
`else
        chk("par_tied_zero", {83'b0, par_err}, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
